// File: rtl/paged_bcd_counter_display.sv
// Free-running counter with start/stop button and clear; value converted to BCD by shift-add-3
// and paged onto DISP_DIGITS 7-seg digits. Optional macro: LEADING_ZERO_BLANK_EN.
module paged_bcd_counter_display #(
  parameter int CNT_W       = 36,
  parameter int NUM_DIGITS  = 12,
  parameter int DISP_DIGITS = 3,
  parameter int PAGE_TICKS  = 25_000_000,
  localparam int NUM_PAGES  = (NUM_DIGITS + DISP_DIGITS - 1) / DISP_DIGITS,
  localparam int PG_W       = $clog2(NUM_PAGES + 1)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     toggle_btn,
  input  logic                     clear,
  output logic                     running,
  output logic                     overflow,
  output logic [7*DISP_DIGITS-1:0] hex,
  output logic [PG_W-1:0]          frame
);

  localparam int SLOTS = NUM_PAGES * DISP_DIGITS;
  localparam int DW_W  = $clog2(PAGE_TICKS);
  localparam int BC_W  = $clog2(CNT_W);

  typedef enum logic [1:0] {CONV_IDLE, CONV_SHIFT, CONV_DONE} conv_state_t;

  logic                     btn_meta, btn_sync, btn_prev;
  logic                     btn_fall;
  logic [CNT_W-1:0]         count;
  logic [DW_W-1:0]          dwell;
  logic [PG_W-1:0]          frame_nxt;
  logic                     page_end;
  logic                     start;
  conv_state_t              conv_state;
  logic [CNT_W-1:0]         snap;
  logic [BC_W-1:0]          bit_cnt;
  logic [4*NUM_DIGITS-1:0]  bcd_work, bcd_adj, disp_bcd;
  logic [4*SLOTS-1:0]       bcd_vis;
  logic [7*DISP_DIGITS-1:0] page_word [NUM_PAGES];
  logic [7*DISP_DIGITS-1:0] hex_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign btn_fall = btn_prev & ~btn_sync;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
      btn_prev <= 1'b1;
      running  <= 1'b1;
    end else begin
      btn_meta <= toggle_btn;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      if (btn_fall) running <= ~running;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (running) begin
      count <= count + 1'b1;
      if (&count) overflow <= 1'b1;
    end
  end

  // frame itself is the page state: 0 = blank, NUM_PAGES..1 = pages, most significant first
  assign page_end = (dwell == DW_W'(PAGE_TICKS - 1));
  assign start    = (frame == '0) && (dwell == '0);

  always_comb begin
    frame_nxt = frame;
    if (page_end) frame_nxt = (frame == '0) ? PG_W'(NUM_PAGES) : frame - PG_W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      conv_state <= CONV_IDLE;
      snap       <= '0;
      bit_cnt    <= '0;
      bcd_work   <= '0;
      disp_bcd   <= '0;
    end else begin
      case (conv_state)
        CONV_IDLE: begin
          if (start) begin
            snap       <= count;
            bit_cnt    <= '0;
            bcd_work   <= '0;
            conv_state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          bcd_work <= {bcd_adj[4*NUM_DIGITS-2:0], snap[CNT_W-1]};
          snap     <= snap << 1;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == BC_W'(CNT_W - 1)) conv_state <= CONV_DONE;
        end
        CONV_DONE: begin
          disp_bcd   <= bcd_work;
          conv_state <= CONV_IDLE;
        end
        default: conv_state <= CONV_IDLE;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
  end

  // Slots past NUM_DIGITS (and blanked leading zeros) become code F, which decodes to blank
  always_comb begin
    bcd_vis = '1;
    bcd_vis[4*NUM_DIGITS-1:0] = disp_bcd;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (bcd_vis[4*i +: 4] == 4'd0) bcd_vis[4*i +: 4] = 4'hF;
      else break;
    end
`endif
  end

  always_comb begin
    for (int p = 0; p < NUM_PAGES; p++)
      for (int k = 0; k < DISP_DIGITS; k++)
        page_word[p][7*k +: 7] = seg7(bcd_vis[4*(p*DISP_DIGITS + k) +: 4]);
  end

  always_comb begin
    hex_nxt = '1;
    for (int p = 0; p < NUM_PAGES; p++)
      if (frame_nxt == PG_W'(p + 1)) hex_nxt = page_word[p];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame <= '0;
      dwell <= '0;
      hex   <= '1;
    end else begin
      frame <= frame_nxt;
      dwell <= page_end ? '0 : dwell + 1'b1;
      hex   <= hex_nxt;
    end
  end

endmodule
